// File: rtl/avg_pkg.sv
// Shared constants, FSM encoding and the reference rounding average for the
// averager stream driver.
package avg_pkg;

    localparam int DEPTH = 128;
    localparam int LAG   = 8;
    localparam int NOUT  = DEPTH - LAG;
    localparam int TMO   = 16;
    localparam int AW    = 7;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ARST    = 3'd1,
        S_FEED    = 3'd2,
        S_COLLECT = 3'd3,
        S_FIN     = 3'd4
    } state_e;

    // Round-half-up average; the 9-bit sum keeps the carry of a + b + 1.
    function automatic logic [7:0] avg_expect(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] sum;
        sum = {1'b0, a} + {1'b0, b} + 9'd1;
        return sum[8:1];
    endfunction

endpackage

// File: rtl/avg_stream_driver_if.sv
// Link between the stream driver (master) and the downstream pairwise averager
// (slave).
interface avg_stream_driver_if;

    logic       avg_reset;
    logic [7:0] avg_data;
    logic       avg_valid;
    logic [7:0] avg_out;

    modport master (
        output avg_reset,
        output avg_data,
        input  avg_valid,
        input  avg_out
    );

    modport slave (
        input  avg_reset,
        input  avg_data,
        output avg_valid,
        output avg_out
    );

endinterface

// File: rtl/avg_sample_ram.sv
// 128x8 storage with one synchronous write port and two asynchronous read
// ports; contents are never cleared by reset.
module avg_sample_ram
    import avg_pkg::*;
(
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic [7:0]    wr_data_i,
    input  logic [AW-1:0] ra_addr_i,
    output logic [7:0]    ra_data_o,
    input  logic [AW-1:0] rb_addr_i,
    output logic [7:0]    rb_data_o
);

    logic [7:0] mem_q [DEPTH];

    // Write port.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign ra_data_o = mem_q[ra_addr_i];
    assign rb_data_o = mem_q[rb_addr_i];

endmodule

// File: rtl/avg_stream_driver.sv
// Feeds a 128-sample frame to the pairwise averager, captures its 120 results
// and counts results that differ from the expected rounded average.
module avg_stream_driver
    import avg_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic [7:0]    wr_data_i,
    input  logic          start_i,
    input  logic [AW-1:0] rd_addr_i,
    output logic [7:0]    rd_data_o,
    output logic          busy_o,
    output logic          done_o,
    output logic          timeout_o,
    output logic [6:0]    err_cnt_o,
    avg_stream_driver_if.master avg
);

    localparam logic [AW-1:0] LAST_FEED = AW'(DEPTH - 1);
    localparam logic [AW-1:0] LAST_CAP  = AW'(NOUT - 1);
    localparam logic [AW-1:0] LAG_W     = AW'(LAG);
    localparam logic [AW-1:0] NOUT_W    = AW'(NOUT);
    localparam logic [4:0]    LAST_IDLE = 5'(TMO - 1);

    state_e        state_q, state_d;
    logic [AW-1:0] feed_q, feed_d;
    logic [AW-1:0] cap_q, cap_d;
    logic [4:0]    idle_q, idle_d;
    logic [6:0]    err_q, err_d;
    logic          tmo_q, tmo_d;
    logic          busy_q, done_q, avg_reset_q;
    logic [7:0]    avg_data_q, avg_data_d;
    logic [7:0]    rd_data_q, rd_data_d;

    logic          smp_we_s;
    logic [AW-1:0] smp_ra_addr_s;
    logic [7:0]    smp_ra_s, smp_rb_s;
    logic [7:0]    exp_s;
    logic          res_we_s;
    logic [7:0]    res_rd_s, res_unused_s;

    assign smp_we_s = wr_en_i && (state_q == S_IDLE);

    // Port A looks one sample ahead while feeding so avg_data can be registered;
    // during collection it supplies the lagged partner sample.
    assign smp_ra_addr_s = (state_q == S_ARST) ? {AW{1'b0}} :
                           (state_q == S_FEED) ? feed_q + 7'd1 :
                                                 cap_q + LAG_W;

    avg_sample_ram u_sample_ram (
        .clk       (clk),
        .we_i      (smp_we_s),
        .wr_addr_i (wr_addr_i),
        .wr_data_i (wr_data_i),
        .ra_addr_i (smp_ra_addr_s),
        .ra_data_o (smp_ra_s),
        .rb_addr_i (cap_q),
        .rb_data_o (smp_rb_s)
    );

    avg_sample_ram u_result_ram (
        .clk       (clk),
        .we_i      (res_we_s),
        .wr_addr_i (cap_q),
        .wr_data_i (avg.avg_out),
        .ra_addr_i (rd_addr_i),
        .ra_data_o (res_rd_s),
        .rb_addr_i (rd_addr_i),
        .rb_data_o (res_unused_s)
    );

    assign exp_s = avg_expect(smp_rb_s, smp_ra_s);

    // Next-state, frame counters and next values of the registered outputs.
    always_comb begin
        state_d  = state_q;
        feed_d   = feed_q;
        cap_d    = cap_q;
        idle_d   = idle_q;
        err_d    = err_q;
        tmo_d    = tmo_q;
        res_we_s = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_ARST;
                    feed_d  = {AW{1'b0}};
                    cap_d   = {AW{1'b0}};
                    idle_d  = 5'd0;
                    err_d   = 7'd0;
                    tmo_d   = 1'b0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ARST: begin
                state_d = S_FEED;
            end
            S_FEED: begin
                if (feed_q == LAST_FEED) begin
                    state_d = S_COLLECT;
                end else begin
                    feed_d = feed_q + 7'd1;
                end
            end
            S_COLLECT: begin
                if (avg.avg_valid) begin
                    res_we_s = 1'b1;
                    idle_d   = 5'd0;
                    cap_d    = cap_q + 7'd1;
                    if ((avg.avg_out != exp_s) && (err_q != 7'd127)) begin
                        err_d = err_q + 7'd1;
                    end else begin
                        err_d = err_q;
                    end
                    if (cap_q == LAST_CAP) begin
                        state_d = S_FIN;
                    end else begin
                        state_d = S_COLLECT;
                    end
                end else begin
                    idle_d = idle_q + 5'd1;
                    if (idle_q == LAST_IDLE) begin
                        tmo_d   = 1'b1;
                        state_d = S_FIN;
                    end else begin
                        state_d = S_COLLECT;
                    end
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        avg_data_d = (state_d == S_FEED) ? smp_ra_s : 8'h00;
        rd_data_d  = (rd_addr_i < NOUT_W) ? res_rd_s : 8'h00;
    end

    // State, counters and registered outputs; reset leaves both buffers intact.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            feed_q      <= {AW{1'b0}};
            cap_q       <= {AW{1'b0}};
            idle_q      <= 5'd0;
            err_q       <= 7'd0;
            tmo_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            avg_reset_q <= 1'b1;
            avg_data_q  <= 8'h00;
            rd_data_q   <= 8'h00;
        end else begin
            state_q     <= state_d;
            feed_q      <= feed_d;
            cap_q       <= cap_d;
            idle_q      <= idle_d;
            err_q       <= err_d;
            tmo_q       <= tmo_d;
            busy_q      <= (state_d != S_IDLE);
            done_q      <= (state_d == S_FIN);
            avg_reset_q <= (state_d == S_ARST);
            avg_data_q  <= avg_data_d;
            rd_data_q   <= rd_data_d;
        end
    end

    assign rd_data_o     = rd_data_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign timeout_o     = tmo_q;
    assign err_cnt_o     = err_q;
    assign avg.avg_reset = avg_reset_q;
    assign avg.avg_data  = avg_data_q;

endmodule

// File: tb/tb_avg_stream_driver.sv
// Frame-level bench: a behavioural averager model answers the driver, and a
// table of frames plus hand sequences check results, counts and timing.
module tb_avg_stream_driver;
    import avg_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       wr_en;
    logic [6:0] wr_addr;
    logic [7:0] wr_data;
    logic       start;
    logic [6:0] rd_addr;
    logic [7:0] rd_data;
    logic       busy, done, timeout;
    logic [6:0] err_cnt;

    avg_stream_driver_if avg_if();

    avg_stream_driver dut (
        .clk       (clk),
        .reset     (reset),
        .wr_en_i   (wr_en),
        .wr_addr_i (wr_addr),
        .wr_data_i (wr_data),
        .start_i   (start),
        .rd_addr_i (rd_addr),
        .rd_data_o (rd_data),
        .busy_o    (busy),
        .done_o    (done),
        .timeout_o (timeout),
        .err_cnt_o (err_cnt),
        .avg       (avg_if)
    );

    always #5 clk = ~clk;

    typedef struct {
        string nm;
        int    pat;
        bit    dead;
        int    inj_idx;
        int    inj_val;
        int    n_rand;
        int    exp_done;
        bit    exp_tmo;
        int    exp_err;
    } frame_vec_t;

    int smp [DEPTH];
    int seen [DEPTH];
    int ref_res [NOUT];
    int res_mem [NOUT];
    bit inj_en [NOUT];
    int inj_val [NOUT];
    bit dead = 1'b0;
    int n_chk = 0;
    int n_fail = 0;
    int done_cnt = 0;
    int mn, mr;

    // Averager model: records the 128 samples after its reset, then returns
    // one rounded pair average per cycle, optionally corrupted or silent.
    initial begin
        avg_if.avg_valid = 1'b0;
        avg_if.avg_out   = 8'h00;
        mn = DEPTH;
        mr = NOUT;
        forever begin
            @(negedge clk);
            if (avg_if.avg_reset === 1'b1) begin
                mn = 0;
                mr = NOUT;
                avg_if.avg_valid = 1'b0;
            end else if (mn < DEPTH) begin
                seen[mn] = int'(avg_if.avg_data);
                mn++;
                if (mn == DEPTH && !dead) mr = 0;
                avg_if.avg_valid = 1'b0;
            end else if (mr < NOUT) begin
                avg_if.avg_valid = 1'b1;
                avg_if.avg_out = inj_en[mr] ? 8'(inj_val[mr])
                                            : 8'((seen[mr] + seen[mr + LAG] + 1) / 2);
                mr++;
            end else begin
                avg_if.avg_valid = 1'b0;
            end
        end
    end

    always @(posedge clk) begin
        if (done === 1'b1) done_cnt <= done_cnt + 1;
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic load(input int pat);
        for (int k = 0; k < DEPTH; k++) begin
            case (pat)
                0:       smp[k] = k;
                1:       smp[k] = (k == 8) ? 1 : 0;
                2:       smp[k] = 255;
                default: smp[k] = int'($urandom_range(0, 255));
            endcase
            wr_en   = 1'b1;
            wr_addr = 7'(k);
            wr_data = 8'(smp[k]);
            @(negedge clk);
        end
        wr_en = 1'b0;
    endtask

    task automatic clear_inj();
        for (int c = 0; c < NOUT; c++) begin
            inj_en[c]  = 1'b0;
            inj_val[c] = 0;
        end
    endtask

    // Expected result buffer from the bench's own samples; returns mismatch count.
    function automatic int calc_ref();
        int e, n;
        n = 0;
        for (int c = 0; c < NOUT; c++) begin
            e = (smp[c] + smp[c + LAG] + 1) / 2;
            ref_res[c] = inj_en[c] ? inj_val[c] : e;
            if (ref_res[c] != e) n++;
        end
        return n;
    endfunction

    task automatic read_all(input string nm);
        for (int a = 0; a < DEPTH; a++) begin
            rd_addr = 7'(a);
            @(negedge clk);
            chk($sformatf("%s rd[%0d]", nm, a), int'(rd_data), (a < NOUT) ? res_mem[a] : 0);
        end
    endtask

    task automatic run_frame(input string nm, input int exp_done, input bit exp_tmo,
                             input int exp_err);
        int cyc;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        chk({nm, " arst"}, int'(avg_if.avg_reset), 1);
        chk({nm, " busy"}, int'(busy), 1);
        while (done !== 1'b1 && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
        chk({nm, " done_cycle"}, cyc, exp_done);
        chk({nm, " timeout"}, int'(timeout), int'(exp_tmo));
        chk({nm, " err_cnt"}, int'(err_cnt), exp_err);
        @(negedge clk);
        chk({nm, " done_pulse"}, int'(done), 0);
        chk({nm, " busy_end"}, int'(busy), 0);
        if (!exp_tmo) begin
            for (int c = 0; c < NOUT; c++) res_mem[c] = ref_res[c];
        end
        read_all(nm);
    endtask

    frame_vec_t vecs [6];

    initial begin
        int e, xe, cyc, first_done, dc0, orig;
        vecs[0] = '{"ramp",     0, 1'b0, -1, 0,   0, 250, 1'b0, 0};
        vecs[1] = '{"rounding", 1, 1'b0, -1, 0,   0, 250, 1'b0, 0};
        vecs[2] = '{"err_inj",  2, 1'b0,  5, 127, 0, 250, 1'b0, 1};
        vecs[3] = '{"dead",     0, 1'b1, -1, 0,   0, 146, 1'b1, 0};
        vecs[4] = '{"rand_inj", 3, 1'b0, -1, 0,   6, 250, 1'b0, -1};
        vecs[5] = '{"rand",     3, 1'b0, -1, 0,   0, 250, 1'b0, 0};

        reset = 1'b1; wr_en = 1'b0; wr_addr = 7'd0; wr_data = 8'd0;
        start = 1'b0; rd_addr = 7'd0;
        for (int c = 0; c < NOUT; c++) res_mem[c] = 0;
        clear_inj();
        repeat (3) @(negedge clk);
        chk("rst busy", int'(busy), 0);
        chk("rst done", int'(done), 0);
        chk("rst timeout", int'(timeout), 0);
        chk("rst err_cnt", int'(err_cnt), 0);
        chk("rst rd_data", int'(rd_data), 0);
        chk("rst avg_data", int'(avg_if.avg_data), 0);
        chk("rst avg_reset", int'(avg_if.avg_reset), 1);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            clear_inj();
            dead = vecs[i].dead;
            load(vecs[i].pat);
            if (vecs[i].inj_idx >= 0) begin
                inj_en[vecs[i].inj_idx]  = 1'b1;
                inj_val[vecs[i].inj_idx] = vecs[i].inj_val;
            end
            for (int j = 0; j < vecs[i].n_rand; j++) begin
                int idx;
                idx = int'($urandom_range(0, NOUT - 1));
                inj_en[idx]  = 1'b1;
                inj_val[idx] = int'($urandom_range(0, 255));
            end
            e = calc_ref();
            xe = (vecs[i].exp_err >= 0) ? vecs[i].exp_err : e;
            run_frame(vecs[i].nm, vecs[i].exp_done, vecs[i].exp_tmo, xe);
            dead = 1'b0;
        end

        // Reset while feeding sample 50, then a clean ramp frame.
        clear_inj();
        load(0);
        e = calc_ref();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        repeat (51) begin
            @(negedge clk);
            cyc++;
        end
        chk("midrst feed k50", int'(avg_if.avg_data), 50);
        chk("midrst busy before", int'(busy), 1);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst busy", int'(busy), 0);
        chk("midrst avg_reset", int'(avg_if.avg_reset), 1);
        chk("midrst avg_data", int'(avg_if.avg_data), 0);
        repeat (2) @(negedge clk);
        chk("midrst avg_reset held", int'(avg_if.avg_reset), 1);
        reset = 1'b0;
        @(negedge clk);
        read_all("midrst keep");
        run_frame("midrst rerun", 250, 1'b0, 0);

        // wr_en during FEED and a second start during COLLECT are both ignored.
        clear_inj();
        load(3);
        e = calc_ref();
        orig = smp[3];
        dc0 = done_cnt;
        first_done = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (cyc < 300) begin
            @(negedge clk);
            cyc++;
            wr_en   = (cyc == 20);
            wr_addr = 7'd3;
            wr_data = 8'(orig ^ 255);
            start   = (cyc == 160);
            if (done === 1'b1 && first_done == 0) first_done = cyc;
        end
        wr_en = 1'b0;
        start = 1'b0;
        chk("ignore done_cycle", first_done, 250);
        chk("ignore done_count", done_cnt - dc0, 1);
        chk("ignore err_cnt", int'(err_cnt), 0);
        chk("ignore busy", int'(busy), 0);
        for (int c = 0; c < NOUT; c++) res_mem[c] = ref_res[c];
        read_all("ignore");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/avg_stream_driver.md
# avg_stream_driver

Drives and checks the 8-bit pairwise averager that sits downstream. A host loads a 128-sample buffer, then pulses `start`. The block resets the averager, streams all 128 samples to it one per cycle, and captures its 120 results into a readable result buffer. It also checks every result against the expected rounded average and counts mismatches.

## Interface
- `DEPTH`, 128: samples per frame.
- `LAG`, 8: distance between averaged sample pairs.
- `NOUT`, `DEPTH-LAG` = 120: results per frame.
- `TMO`, 16: consecutive idle `avg_valid` cycles tolerated while collecting.
- `clk` in 1: clock.
- `reset` in 1: reset, synchronous, active-high.
- `wr_en` in 1: sample buffer write strobe.
- `wr_addr` in 7: sample index.
- `wr_data` in 8: sample value.
- `start` in 1: begin frame; single-cycle pulse.
- `rd_addr` in 7: result index.
- `rd_data` out 8: result buffer read data, 1-cycle latency.
- `busy` out 1: frame in progress.
- `done` out 1: one-cycle pulse at frame end.
- `timeout` out 1: sticky; frame ended on timeout.
- `err_cnt` out 7: mismatch count for the current/last frame.
- `avg_reset` out 1: averager reset.
- `avg_data` out 8: sample to averager.
- `avg_valid` in 1: averager result strobe.
- `avg_out` in 8: averager result.

## Operation
- States: IDLE, ARST, FEED, COLLECT, FIN.
- IDLE:
  - `wr_en` writes `sample[wr_addr] <= wr_data`.
  - `start` clears `err_cnt`, `timeout`, feed index and capture index, then goes to ARST.
- ARST: `avg_reset` = 1 for exactly one cycle, then FEED.
- FEED:
  - `avg_data` = `sample[k]` for k = 0..127, one per cycle.
  - After k = 127, go to COLLECT.
- COLLECT:
  - On each cycle with `avg_valid` = 1: `result[c] <= avg_out`, compare against `exp(c)`, increment c.
  - `exp(c)` = (`sample[c]` + `sample[c+LAG]` + 1) >> 1, computed in 9 bits. This is a round-half-up average.
  - On mismatch: `err_cnt` += 1, saturating at 127.
  - Any cycle with `avg_valid` = 0 increments an idle counter; any cycle with `avg_valid` = 1 clears it.
  - c reaching 120 → FIN.
  - Idle counter reaching `TMO` → set `timeout`, then FIN.
  - `avg_valid` after c = 120 is ignored.
- FIN: `done` = 1 for one cycle, then IDLE.
- `busy` = 1 in ARST, FEED, COLLECT and FIN.
- Ignored inputs:
  - `wr_en` while busy is ignored; the sample buffer is frozen during a frame.
  - `start` while busy is ignored.
  - `start` and `wr_en` in the same IDLE cycle: the write lands first, then the frame starts.
- Reads: `rd_addr` is readable in any state. `rd_addr` ≥ 120 returns 0.
- `avg_data` = 0 outside FEED.
- Reset values:
  - state IDLE.
  - `busy`, `done`, `timeout`, `err_cnt`, `rd_data`, `avg_data` = 0.
  - `avg_reset` = 1.
  - Buffers are not cleared.
- Reset mid-frame: returns to IDLE next cycle; `avg_reset` = 1 while `reset` is held; partial results remain in the buffer.

## Timing
- All outputs are registered.
- Frame start:
  - `start` sampled at edge e0.
  - ARST occupies cycle 1.
  - FEED occupies cycles 2..129; sample k is on `avg_data` during cycle 2+k.
- The averager's first result is expected at cycle 130, the first COLLECT cycle.
- Fault-free frame: c = 120 captured at the edge ending cycle 249. FIN is cycle 250, so `done` is high in cycle 250.
- Timeout frame: FIN follows the 16th consecutive idle cycle.
- `err_cnt` is final when `done` is high.
- `rd_data` reflects `rd_addr` from the previous edge.

## Structure
- Package `avg_pkg`:
  - `DEPTH`, `LAG`, `NOUT`, `TMO`.
  - State enum.
  - Function `avg_expect(a, b)` returning the 8-bit round-half-up average.
- Sub-module `avg_sample_ram`: 128x8, one write port, two asynchronous read ports (feed index and check index).
- The result buffer is a second instance with its read port registered in the parent.

## Test plan
- Ramp: `sample[k]` = k, paired with a correct averager model → `result[c]` = c+4 for all c; `err_cnt` = 0; `done` at cycle 250; `timeout` = 0.
- Rounding: all samples 0 except `sample[8]` = 1 → `result[0]` = 1, `result[8]` = 1, all other results 0; `err_cnt` = 0.
- Error injection: all samples 255; the model returns 0x7F for result 5 → `result[5]` = 0x7F; `err_cnt` = 1; all other results 0xFF.
- Dead averager: `avg_valid` held 0 → `done` 16 cycles after COLLECT entry; `timeout` = 1; `err_cnt` = 0.
- Reset at FEED k = 50 → `busy` = 0 the next cycle and `avg_reset` = 1 while `reset` is held. A subsequent `start` runs a full ramp frame with `err_cnt` = 0.
- Ignored inputs: `wr_en` during FEED and a second `start` during COLLECT → sample buffer unchanged, exactly one `done` pulse.
